cpu_dma_engine: RTL and testbench
=================================

# cpu_dma_engine

Multi-channel bus-master DMA engine for the 2a03 CPU subsystem, a parametrised generalisation of the single sprite-DMA path. It snoops CPU writes to a per-channel register window, halts the CPU through a request/acknowledge handshake, and copies a block of bytes from a source page to a destination address over the shared system bus. It sits beside `cpu_2a03`. Its bus outputs are muxed onto the system bus while `bus_own` is high.

## Interface
- `NUM_CH`, 2: number of independent channels, 1..8.
- `LEN_W`, 8: length register width, 1..8. A length value of 0 means 2^LEN_W bytes.
- `REG_BASE`, 16'h4014: address of channel 0 register 0. Channel n occupies REG_BASE+4n .. REG_BASE+4n+3.
- `DST_INC`, 0: 0 keeps the destination address fixed (port-style); 1 increments it after each byte, wrapping at 16 bits.
- `DST_RESET`, 16'h2004: reset value of every channel's destination register.

Ports:
- `clock` in 1: system clock (CPU rate).
- `nreset` in 1: reset, synchronous, active-high; clock `clock`.
- `cpu_addr` in 16: CPU address bus, snooped.
- `cpu_data_out` in 8: CPU write data, snooped.
- `cpu_rw` in 1: CPU direction; 0 means write.
- `halt_ack` in 1: CPU is stalled and the bus is free.
- `dma_data_in` in 8: read data from the system bus.
- `cpu_halt` out 1: stall request to the CPU.
- `bus_own` out 1: DMA drives the bus.
- `dma_addr` out 16: DMA address.
- `dma_data_out` out 8: DMA write data.
- `dma_rw` out 1: DMA direction; 0 means write.
- `busy` out NUM_CH: channel is pending or active.
- `done` out NUM_CH: one-cycle completion pulse.

## Operation
- Register writes are taken when `cpu_rw`=0 and `cpu_addr` hits the window, sampled at the clock edge. The four offsets are:
  - +0: source page. A write loads the page and sets the channel pending (start).
  - +1: length.
  - +2: destination low byte.
  - +3: destination high byte.
- Writes to an active channel's registers are ignored. A pending (not yet active) channel accepts a new page and stays pending.
- States: IDLE, HALT, [ALIGN], READ, WRITE, DONE.
  - IDLE: if any channel is pending, go to HALT. `cpu_halt` is asserted from HALT until DONE exits.
  - HALT: wait for `halt_ack`=1 sampled at an edge. Then select the lowest-index pending channel, load its byte index to 0, and go to ALIGN or READ.
  - READ: `bus_own`=1, `dma_rw`=1, `dma_addr`={page, idx}. Latch `dma_data_in` at the edge. Go to WRITE.
  - WRITE: `bus_own`=1, `dma_rw`=0, `dma_addr`=dest, `dma_data_out`=latched byte. Increment idx; increment dest if DST_INC. If idx+1 equals the length, go to DONE; otherwise go to READ.
  - DONE: pulse `done[ch]` and clear `busy[ch]`. If another channel is pending, go directly to READ for that channel, keeping `cpu_halt` high and skipping the handshake and alignment. Otherwise go to IDLE.
- Source address: the low byte is idx[7:0] with no carry into the page, so transfers never leave the source page.
- Channels are serviced by fixed priority. A transfer is never pre-empted.
- `halt_ack` dropping during a transfer is ignored; the engine owns the bus until DONE.
- Reset values (`nreset`=1 aborts any transfer):
  - State IDLE.
  - `cpu_halt`=0, `bus_own`=0, `dma_addr`=0, `dma_data_out`=0, `dma_rw`=1.
  - `busy`=0, `done`=0.
  - All pages and lengths 0; all destinations DST_RESET.

## Timing
- Start-register write at edge T: `busy` and `cpu_halt` are high from T+1.
- If `halt_ack` is seen at edge A, the first READ cycle is A+1 (A+1 or A+2 with alignment).
- Each byte takes 2 cycles. N bytes occupy exactly 2N cycles of `bus_own`.
- DONE is one cycle. `done` is high during it, and `cpu_halt` drops at the end of DONE when the engine returns to IDLE.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Configuration
- `CPU_DMA_ALIGN_EN` defined:
  - A free-running 1-bit parity counter toggles every cycle; reset value 0.
  - After the handshake, the ALIGN state inserts one idle cycle (`bus_own`=1, `dma_rw`=1, `dma_addr`=src) if parity is 1, so READ always starts on an even cycle. This matches 2a03 513/514-cycle DMA.
- Undefined: there is no ALIGN state and READ follows the handshake directly.

## Test plan
- Ch0, length 3, page 8'h02, DST_INC=0; CPU writes 8'h02 to 16'h4014; `halt_ack` raised 2 cycles later -> reads 0200, 0201, 0202, each followed by a write to 2004. `bus_own` is high for 6 cycles, then `done[0]` pulses and `cpu_halt` drops.
- Length 0, LEN_W=8 -> 256 read/write pairs. The last read is 02FF, with no carry to 0300.
- Both channels started in the same idle window, ch1 first -> ch0 still runs first. Ch1 follows immediately with no gap in `cpu_halt` and no second handshake.
- With `CPU_DMA_ALIGN_EN`, `halt_ack` seen on an odd-parity cycle -> exactly one ALIGN cycle precedes READ. On an even-parity cycle -> none.
- `nreset` asserted mid-WRITE -> next cycle all outputs are at reset values and `busy`=0. A subsequent start works normally.
- Write to ch0 length register while ch0 is active -> ignored; the current and the next transfer use the old length.

Source files
------------

// File: rtl/cpu_dma_engine_if.sv
// ============================================================================
//  Module   : cpu_dma_engine_if
//  Purpose  : CPU snoop, halt handshake and system-bus signals of the DMA engine.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface cpu_dma_engine_if #(
    parameter int NUM_CH = 2
);
    logic [15:0]       cpu_addr;
    logic [7:0]        cpu_data_out;
    logic              cpu_rw;
    logic              halt_ack;
    logic [7:0]        dma_data_in;
    logic              cpu_halt;
    logic              bus_own;
    logic [15:0]       dma_addr;
    logic [7:0]        dma_data_out;
    logic              dma_rw;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] done;

    // The DMA engine is the master of the shared bus.
    modport master (
        input  cpu_addr, cpu_data_out, cpu_rw, halt_ack, dma_data_in,
        output cpu_halt, bus_own, dma_addr, dma_data_out, dma_rw, busy, done
    );

    modport slave (
        output cpu_addr, cpu_data_out, cpu_rw, halt_ack, dma_data_in,
        input  cpu_halt, bus_own, dma_addr, dma_data_out, dma_rw, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/cpu_dma_engine.sv
// ============================================================================
//  Module   : cpu_dma_engine
//  Purpose  : Multi-channel bus-master DMA (page-to-address copy) for the 2a03.
//             Optional macro CPU_DMA_ALIGN_EN adds an even-cycle ALIGN state.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module cpu_dma_engine #(
    parameter int          NUM_CH    = 2,
    parameter int          LEN_W     = 8,
    parameter logic [15:0] REG_BASE  = 16'h4014,
    parameter int          DST_INC   = 0,
    parameter logic [15:0] DST_RESET = 16'h2004
) (
    input  wire logic        clock,
    input  wire logic        nreset,
    cpu_dma_engine_if.master bus
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int WIN  = 4 * NUM_CH;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
`ifdef CPU_DMA_ALIGN_EN
        , S_ALIGN = 3'd5
`endif
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [7:0]        r_page [NUM_CH];
    logic [LEN_W-1:0]  r_len  [NUM_CH];
    logic [15:0]       r_dest [NUM_CH];
    logic [NUM_CH-1:0] r_pend;
    logic [NUM_CH-1:0] r_busy;
    logic [CH_W-1:0]   r_ch;
    logic [LEN_W-1:0]  r_idx;
    logic [7:0]        r_byte;
`ifdef CPU_DMA_ALIGN_EN
    logic              r_parity;
`endif

    logic [15:0]       w_off;
    logic              w_hit;
    logic [CH_W-1:0]   w_ch;
    logic [1:0]        w_reg;
    logic              w_engaged;
    logic [NUM_CH-1:0] w_cur_oh;
    logic [NUM_CH-1:0] w_active;
    logic              w_wr;
    logic [NUM_CH-1:0] w_start;
    logic [NUM_CH-1:0] w_cand;
    logic [CH_W-1:0]   w_sel;
    logic              w_sel_vld;
    logic              w_load;
    logic [LEN_W-1:0]  w_idx_nxt;
    logic              w_last;
    logic [15:0]       w_src;

    // Register window decode; a write to the channel currently owning the bus is dropped.
    assign w_off     = bus.cpu_addr - REG_BASE;
    assign w_hit     = (w_off < 16'(WIN));
    assign w_ch      = w_off[CH_W+1:2];
    assign w_reg     = w_off[1:0];
    assign w_engaged = (r_state == S_READ) || (r_state == S_WRITE) || (r_state == S_DONE)
`ifdef CPU_DMA_ALIGN_EN
                       || (r_state == S_ALIGN)
`endif
                       ;
    assign w_cur_oh  = NUM_CH'(1) << r_ch;
    assign w_active  = w_engaged ? w_cur_oh : '0;
    assign w_wr      = !bus.cpu_rw && w_hit && !w_active[w_ch];
    assign w_start   = (w_wr && (w_reg == 2'd0)) ? (NUM_CH'(1) << w_ch) : '0;
    assign w_cand    = r_pend | w_start;

    assign w_idx_nxt = r_idx + LEN_W'(1);
    assign w_last    = (w_idx_nxt == r_len[r_ch]);
    assign w_src     = {r_page[r_ch], 8'(r_idx)};

    // Fixed priority: lowest index wins.
    always_comb begin
        w_sel     = '0;
        w_sel_vld = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_sel     = CH_W'(i);
                w_sel_vld = 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            S_IDLE:  if (w_sel_vld) w_next = S_HALT;
            S_HALT: begin
                if (bus.halt_ack && w_sel_vld) begin
                    w_load = 1'b1;
`ifdef CPU_DMA_ALIGN_EN
                    w_next = r_parity ? S_ALIGN : S_READ;
`else
                    w_next = S_READ;
`endif
                end
            end
`ifdef CPU_DMA_ALIGN_EN
            S_ALIGN: w_next = S_READ;
`endif
            S_READ:  w_next = S_WRITE;
            S_WRITE: w_next = w_last ? S_DONE : S_READ;
            S_DONE: begin
                // Chained channel keeps the CPU halted and skips the handshake.
                if (w_sel_vld) begin
                    w_load = 1'b1;
                    w_next = S_READ;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (nreset) begin
            r_state <= S_IDLE;
            r_pend  <= '0;
            r_busy  <= '0;
            r_ch    <= '0;
            r_idx   <= '0;
            r_byte  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_page[i] <= '0;
                r_len[i]  <= '0;
                r_dest[i] <= DST_RESET;
            end
        end else begin
            r_state <= w_next;
            r_pend  <= (r_pend | w_start) & ~(w_load ? (NUM_CH'(1) << w_sel) : '0);
            r_busy  <= (r_busy | w_start) & ~((r_state == S_DONE) ? w_cur_oh : '0);

            if (w_wr) begin
                case (w_reg)
                    2'd0:    r_page[w_ch]       <= bus.cpu_data_out;
                    2'd1:    r_len[w_ch]        <= bus.cpu_data_out[LEN_W-1:0];
                    2'd2:    r_dest[w_ch][7:0]  <= bus.cpu_data_out;
                    default: r_dest[w_ch][15:8] <= bus.cpu_data_out;
                endcase
            end

            if (w_load) begin
                r_ch  <= w_sel;
                r_idx <= '0;
            end

            if (r_state == S_READ) r_byte <= bus.dma_data_in;

            if (r_state == S_WRITE) begin
                r_idx <= w_idx_nxt;
                if (DST_INC != 0) r_dest[r_ch] <= r_dest[r_ch] + 16'd1;
            end
        end
    end

`ifdef CPU_DMA_ALIGN_EN
    always_ff @(posedge clock) begin
        if (nreset) r_parity <= 1'b0;
        else        r_parity <= ~r_parity;
    end
`endif

    // Outputs depend only on state and registers.
    logic        w_bus_own;
    logic        w_rw;
    logic [15:0] w_addr;
    logic [7:0]  w_dout;

    always_comb begin
        w_bus_own = 1'b0;
        w_rw      = 1'b1;
        w_addr    = '0;
        w_dout    = '0;
        case (r_state)
`ifdef CPU_DMA_ALIGN_EN
            S_ALIGN: begin
                w_bus_own = 1'b1;
                w_addr    = w_src;
            end
`endif
            S_READ: begin
                w_bus_own = 1'b1;
                w_addr    = w_src;
            end
            S_WRITE: begin
                w_bus_own = 1'b1;
                w_rw      = 1'b0;
                w_addr    = r_dest[r_ch];
                w_dout    = r_byte;
            end
            default: ;
        endcase
    end

    assign bus.cpu_halt     = (r_state != S_IDLE);
    assign bus.bus_own      = w_bus_own;
    assign bus.dma_rw       = w_rw;
    assign bus.dma_addr     = w_addr;
    assign bus.dma_data_out = w_dout;
    assign bus.busy         = r_busy;
    assign bus.done         = (r_state == S_DONE) ? w_cur_oh : '0;

endmodule

`default_nettype wire

// File: tb/tb_cpu_dma_engine.sv
// ============================================================================
//  Module   : tb_cpu_dma_engine
//  Purpose  : Scoreboard bench for cpu_dma_engine bus cycles and done pulses.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cpu_dma_engine;
    localparam int NUM_CH = 2;

    logic clock  = 1'b0;
    logic nreset = 1'b1;

    cpu_dma_engine_if #(.NUM_CH(NUM_CH)) bus ();

    cpu_dma_engine #(
        .NUM_CH   (NUM_CH),
        .LEN_W    (8),
        .REG_BASE (16'h4014),
        .DST_INC  (0),
        .DST_RESET(16'h2004)
    ) dut (
        .clock (clock),
        .nreset(nreset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] mem(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
    endfunction

    assign bus.dma_data_in = mem(bus.dma_addr);

    typedef enum int {K_RD, K_WR, K_DONE} kind_t;
    typedef struct {
        kind_t             kind;
        logic [15:0]       addr;
        logic [7:0]        data;
        logic [NUM_CH-1:0] dn;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

`ifdef CPU_DMA_ALIGN_EN
    logic tb_par = 1'b0;
    always @(posedge clock) tb_par <= nreset ? 1'b0 : ~tb_par;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endtask

    function automatic void push_rd(input logic [15:0] a, input bit front);
        exp_t e;
        e.kind = K_RD; e.addr = a; e.data = 8'h00; e.dn = '0;
        if (front) q.push_front(e);
        else       q.push_back(e);
    endfunction

    function automatic void push_wr(input logic [15:0] a, input logic [7:0] d);
        exp_t e;
        e.kind = K_WR; e.addr = a; e.data = d; e.dn = '0;
        q.push_back(e);
    endfunction

    function automatic void push_xfer(input int ch, input logic [7:0] page, input int nbytes,
                                      input logic [15:0] dst);
        exp_t e;
        for (int i = 0; i < nbytes; i++) begin
            push_rd({page, 8'(i)}, 1'b0);
            push_wr(dst, mem({page, 8'(i)}));
        end
        e.kind = K_DONE; e.addr = '0; e.data = '0; e.dn = NUM_CH'(1) << ch;
        q.push_back(e);
    endfunction

    // Monitor: every bus_own cycle and every done pulse consumes one expected item.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (bus.bus_own) begin
                if (q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL bus_unexpected: actual addr %0h rw %0b required none",
                             bus.dma_addr, bus.dma_rw);
                end else begin
                    e = q.pop_front();
                    chk("bus_kind", 32'(bus.dma_rw), (e.kind == K_RD) ? 32'd1 :
                                                     (e.kind == K_WR) ? 32'd0 : 32'd2);
                    chk("bus_addr", 32'(bus.dma_addr), 32'(e.addr));
                    if (e.kind == K_WR) chk("bus_wdata", 32'(bus.dma_data_out), 32'(e.data));
                    chk("bus_halt", 32'(bus.cpu_halt), 32'd1);
                end
            end
            if (bus.done != '0) begin
                if (q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL done_unexpected: actual %0h required none", bus.done);
                end else begin
                    e = q.pop_front();
                    chk("done_kind", 32'(e.kind), 32'(K_DONE));
                    chk("done_vec", 32'(bus.done), 32'(e.dn));
                    chk("done_halt", 32'(bus.cpu_halt), 32'd1);
                end
            end
        end
    end

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge clock);
        bus.cpu_addr     = a;
        bus.cpu_data_out = d;
        bus.cpu_rw       = 1'b0;
        @(negedge clock);
        bus.cpu_rw       = 1'b1;
        bus.cpu_addr     = 16'h0000;
    endtask

    task automatic raise_ack(input logic [7:0] first_page, output int al);
        @(negedge clock);
        bus.halt_ack = 1'b1;
        al = 0;
`ifdef CPU_DMA_ALIGN_EN
        if (tb_par) begin
            al = 1;
            push_rd({first_page, 8'h00}, 1'b1);
        end
`else
        if (first_page === 8'hxx) al = 0;
`endif
    endtask

    // Grant the bus, then count halted cycles until cpu_halt falls.
    task automatic go(input logic [7:0] first_page, input int exp_cyc, input string nm);
        int cnt;
        int al;
        raise_ack(first_page, al);
        cnt = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clock);
            if (i == 0) chk({nm, "_first_bus"}, {31'd0, bus.bus_own & bus.dma_rw}, 32'd1);
            if (!bus.cpu_halt) break;
            cnt++;
        end
        chk({nm, "_halt_cycles"}, 32'(cnt), 32'(exp_cyc + al));
        bus.halt_ack = 1'b0;
        chk({nm, "_busy_clear"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_cpu_halt"}, 32'(bus.cpu_halt), 32'd0);
        chk({nm, "_bus_own"}, 32'(bus.bus_own), 32'd0);
        chk({nm, "_dma_addr"}, 32'(bus.dma_addr), 32'd0);
        chk({nm, "_dma_dout"}, 32'(bus.dma_data_out), 32'd0);
        chk({nm, "_dma_rw"}, 32'(bus.dma_rw), 32'd1);
        chk({nm, "_busy"}, 32'(bus.busy), 32'd0);
        chk({nm, "_done"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        bit seen;
        int al;
        bus.cpu_addr     = 16'h0000;
        bus.cpu_data_out = 8'h00;
        bus.cpu_rw       = 1'b1;
        bus.halt_ack     = 1'b0;
        repeat (3) @(negedge clock);
        nreset = 1'b0;
        chk_reset_outputs("reset");

        // Single channel, 3 bytes from page 02 to the fixed port 2004.
        push_xfer(0, 8'h02, 3, 16'h2004);
        cpu_wr(16'h4015, 8'd3);
        cpu_wr(16'h4014, 8'h02);
        chk("t1_busy", 32'(bus.busy), 32'h1);
        chk("t1_halt", 32'(bus.cpu_halt), 32'd1);
        go(8'h02, 7, "t1");

        // Ch1 started before ch0: ch0 still runs first, ch1 chains without a handshake.
        cpu_wr(16'h4019, 8'd2);
        cpu_wr(16'h401A, 8'h34);
        cpu_wr(16'h401B, 8'h12);
        chk("t3_no_start", 32'(bus.busy), 32'd0);
        push_xfer(0, 8'h06, 3, 16'h2004);
        push_xfer(1, 8'h05, 2, 16'h1234);
        cpu_wr(16'h4018, 8'h05);
        cpu_wr(16'h4014, 8'h06);
        chk("t3_busy", 32'(bus.busy), 32'h3);
        go(8'h06, 12, "t3");

        // Length 0 means 256 bytes; the source wraps within page 02.
        push_xfer(1, 8'h02, 256, 16'h1234);
        cpu_wr(16'h4019, 8'd0);
        cpu_wr(16'h4018, 8'h02);
        go(8'h02, 513, "t2");

        // Reset during the first WRITE, then a fresh transfer.
        push_rd(16'h0700, 1'b0);
        push_wr(16'h2004, mem(16'h0700));
        cpu_wr(16'h4014, 8'h07);
        raise_ack(8'h07, al);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (bus.bus_own && !bus.dma_rw) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t4_write_seen", 32'(seen), 32'd1);
        nreset       = 1'b1;
        bus.halt_ack = 1'b0;
        @(negedge clock);
        nreset = 1'b0;
        chk_reset_outputs("t4_reset");
        cpu_wr(16'h4015, 8'd2);
        push_xfer(0, 8'h09, 2, 16'h2004);
        cpu_wr(16'h4014, 8'h09);
        go(8'h09, 5, "t4_after");

        // Length write while ch0 is active is dropped for this and the next transfer.
        push_xfer(0, 8'h0A, 2, 16'h2004);
        cpu_wr(16'h4014, 8'h0A);
        raise_ack(8'h0A, al);
        cpu_wr(16'h4015, 8'd7);
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (!bus.cpu_halt) break;
        end
        bus.halt_ack = 1'b0;
        chk("t5_halt_low", 32'(bus.cpu_halt), 32'd0);
        chk("t5_busy", 32'(bus.busy), 32'd0);
        push_xfer(0, 8'h0B, 2, 16'h2004);
        cpu_wr(16'h4014, 8'h0B);
        go(8'h0B, 5, "t5_next");

        repeat (4) @(negedge clock);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire
